// File: rtl/adder8b_arbiter_if.sv
// Request/result bundle between the two client FSMs and the shared-adder arbiter.
interface adder8b_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0;
  logic [7:0]       a0;
  logic [7:0]       b0;
  logic             cin0;
  logic             req1;
  logic [7:0]       a1;
  logic [7:0]       b1;
  logic             cin1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [7:0]       sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Client side: raises requests and operands, watches grants and results.
  modport master (
    output req0, a0, b0, cin0, req1, a1, b1, cin1,
    input  gnt0, gnt1, done0, done1, sum, cout, ovf, busy, op_count
  );

  // Arbiter side.
  modport slave (
    input  req0, a0, b0, cin0, req1, a1, b1, cin1,
    output gnt0, gnt1, done0, done1, sum, cout, ovf, busy, op_count
  );
endinterface

// File: rtl/adder8b_arbiter.sv
// Round-robin arbiter sharing one 8-bit ripple adder between two 4-phase
// req/done requesters. Results are registered and held until release.
//
// state | meaning
// IDLE  | no owner; pick a winner when any req is high and latch its operands
// CALC  | adder sees latched operands; result and done registered at next edge
// ACK   | result held; wait for the winner's req to fall, then rotate pointer
module adder8b_arbiter #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  adder8b_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state_q;
  logic             win_q;
  logic             last_q;
  logic [7:0]       opa_q;
  logic [7:0]       opb_q;
  logic             opc_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done0_q;
  logic             done1_q;
  logic [7:0]       sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             win_d;
  logic             win_req;
  logic [7:0]       add_s;
  logic             add_co;
  logic [8:0]       carry;

  // Winner selection: a lone request wins; on contention the one that was not served last wins.
  always_comb begin
    win_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_d = ~last_q;
    end else if (bus.req1) begin
      win_d = 1'b1;
    end
    win_req = win_q ? bus.req1 : bus.req0;
  end

  // Shared 8-bit ripple adder, driven only from the latched operand registers.
  always_comb begin
    carry    = '0;
    add_s    = '0;
    carry[0] = opc_q;
    for (int i = 0; i < 8; i++) begin
      add_s[i]     = opa_q[i] ^ opb_q[i] ^ carry[i];
      carry[i+1]   = (opa_q[i] & opb_q[i]) | (carry[i] & (opa_q[i] ^ opb_q[i]));
    end
    add_co = carry[8];
  end

  // Arbitration FSM with registered grant, done and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            win_q   <= win_d;
            opa_q   <= win_d ? bus.a1 : bus.a0;
            opb_q   <= win_d ? bus.b1 : bus.b0;
            opc_q   <= win_d ? bus.cin1 : bus.cin0;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          sum_q   <= add_s;
          cout_q  <= add_co;
          ovf_q   <= (opa_q[7] == opb_q[7]) && (add_s[7] != opa_q[7]);
          done0_q <= ~win_q;
          done1_q <= win_q;
          state_q <= ACK;
        end
        ACK: begin
          if (!win_req) begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= win_q;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_adder8b_arbiter.sv
// Bench for the shared-adder arbiter: directed requests, scoreboarded results.
module tb_adder8b_arbiter;

  logic clk;
  logic rst;

  typedef struct packed {
    logic       id;
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  logic pd0, pd1;

  adder8b_arbiter_if #(.CNT_W(16)) bus ();
  adder8b_arbiter_if #(.CNT_W(2))  bus2 ();

  adder8b_arbiter #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  adder8b_arbiter #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] s, input logic c, input logic v);
    exp_t e;
    e.id = id; e.s = s; e.c = c; e.v = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic id);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done actual=requester%0d required=none", id);
    end else begin
      e = sb.pop_front();
      chk("sb_id", 32'(id), 32'(e.id));
      chk("sb_sum", 32'(bus.sum), 32'(e.s));
      chk("sb_cout", 32'(bus.cout), 32'(e.c));
      chk("sb_ovf", 32'(bus.ovf), 32'(e.v));
    end
  endtask

  task automatic wait_done(input logic id, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((id ? bus.done1 : bus.done0) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_within_budget", 32'(found), 32'd1);
  endtask

  task automatic chk_all_zero();
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_done0", 32'(bus.done0), 0);
    chk("rst_done1", 32'(bus.done1), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_cout", 32'(bus.cout), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_op_count", 32'(bus.op_count), 0);
  endtask

  // Monitor: every rising done pops one expected result.
  initial begin
    pd0 = 1'b0;
    pd1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.done0 && !pd0) pop_cmp(1'b0);
        if (bus.done1 && !pd1) pop_cmp(1'b1);
      end
      pd0 = bus.done0;
      pd1 = bus.done1;
    end
  end

  initial begin
    int   k;
    logic found;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0 = 0; bus.a0 = 0; bus.b0 = 0; bus.cin0 = 0;
    bus.req1 = 0; bus.a1 = 0; bus.b1 = 0; bus.cin1 = 0;
    bus2.req0 = 0; bus2.a0 = 8'd1; bus2.b0 = 8'd1; bus2.cin0 = 0;
    bus2.req1 = 0; bus2.a1 = 0; bus2.b1 = 0; bus2.cin1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero();

    // Single requester 0: 10 + 5
    bus.a0 = 8'd10; bus.b0 = 8'd5; bus.cin0 = 0;
    push(1'b0, 8'd15, 1'b0, 1'b0);
    bus.req0 = 1;
    @(negedge clk);
    chk("single_gnt0", 32'(bus.gnt0), 1);
    chk("single_done0_early", 32'(bus.done0), 0);
    chk("single_busy", 32'(bus.busy), 1);
    wait_done(1'b0, 1);
    bus.req0 = 0;
    @(negedge clk);
    chk("single_release_done0", 32'(bus.done0), 0);
    chk("single_release_gnt0", 32'(bus.gnt0), 0);
    chk("single_op_count", 32'(bus.op_count), 1);
    chk("single_idle", 32'(bus.busy), 0);

    // Requester 1 signed overflow: 127 + 1; a1 changes during CALC
    bus.a1 = 8'd127; bus.b1 = 8'd1; bus.cin1 = 0;
    push(1'b1, 8'd128, 1'b0, 1'b1);
    bus.req1 = 1;
    @(negedge clk);
    chk("ovf_gnt1", 32'(bus.gnt1), 1);
    chk("ovf_gnt0", 32'(bus.gnt0), 0);
    bus.a1 = 8'd0;
    wait_done(1'b1, 1);
    @(negedge clk);
    chk("ack_hold_done1", 32'(bus.done1), 1);
    chk("ack_hold_sum", 32'(bus.sum), 128);
    bus.req1 = 0;
    @(negedge clk);
    chk("ovf_release_done1", 32'(bus.done1), 0);
    chk("ovf_op_count", 32'(bus.op_count), 2);
    chk("post_release_sum", 32'(bus.sum), 128);
    chk("post_release_ovf", 32'(bus.ovf), 1);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero();
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: 0 first, then 1, then 0 again
    bus.a0 = 8'd200; bus.b0 = 8'd100; bus.cin0 = 1;
    bus.a1 = 8'hFF;  bus.b1 = 8'h01;  bus.cin1 = 0;
    push(1'b0, 8'd45, 1'b1, 1'b0);
    push(1'b1, 8'd0,  1'b1, 1'b0);
    push(1'b0, 8'd4,  1'b0, 1'b0);
    bus.req0 = 1; bus.req1 = 1;
    @(negedge clk);
    chk("cont1_gnt0", 32'(bus.gnt0), 1);
    chk("cont1_gnt1", 32'(bus.gnt1), 0);
    wait_done(1'b0, 2);
    bus.req0 = 0;
    @(negedge clk);
    chk("cont_gap_busy", 32'(bus.busy), 0);
    bus.a0 = 8'd1; bus.b0 = 8'd2; bus.cin0 = 1;
    bus.req0 = 1;
    @(negedge clk);
    chk("cont2_gnt1", 32'(bus.gnt1), 1);
    chk("cont2_gnt0", 32'(bus.gnt0), 0);
    wait_done(1'b1, 2);
    bus.req1 = 0;
    @(negedge clk);
    chk("cont_gap2_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("cont3_gnt0", 32'(bus.gnt0), 1);
    wait_done(1'b0, 2);
    bus.req0 = 0;
    @(negedge clk);
    chk("cont_op_count", 32'(bus.op_count), 3);

    // Reset while requester 0 is in ACK
    bus.a0 = 8'd9; bus.b0 = 8'd9; bus.cin0 = 0;
    push(1'b0, 8'd18, 1'b0, 1'b0);
    bus.req0 = 1;
    wait_done(1'b0, 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ackrst_done0", 32'(bus.done0), 0);
    chk("ackrst_gnt0", 32'(bus.gnt0), 0);
    chk("ackrst_op_count", 32'(bus.op_count), 0);
    chk("ackrst_busy", 32'(bus.busy), 0);
    bus.req0 = 0;
    rst = 1'b0;
    @(negedge clk);
    bus.a1 = 8'd3; bus.b1 = 8'd4; bus.cin1 = 1;
    push(1'b1, 8'd8, 1'b0, 1'b0);
    bus.req1 = 1;
    @(negedge clk);
    chk("after_rst_gnt1", 32'(bus.gnt1), 1);
    wait_done(1'b1, 2);
    bus.req1 = 0;
    @(negedge clk);
    chk("after_rst_op_count", 32'(bus.op_count), 1);

    // Counter wrap on the CNT_W=2 instance
    for (k = 1; k <= 4; k++) begin
      bus2.req0 = 1;
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus2.done0 === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      chk("wrap_done_within_budget", 32'(found), 1);
      chk("wrap_sum", 32'(bus2.sum), 2);
      bus2.req0 = 0;
      @(negedge clk);
      chk("wrap_op_count", 32'(bus2.op_count), 32'(k % 4));
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder8b_arbiter.md
Name: adder8b_arbiter

Overview:
- Shares one instance of the team's 8-bit ripple adder (adder8b: S, Cout, A, B, Cin) between two requesters.
- Each requester uses a 4-phase req/done handshake. The block arbitrates round-robin, latches the winner's operands and computes the sum. It registers sum, carry and signed overflow, and holds them until the requester releases.
- Sits between two client FSMs and the shared adder datapath. It is the adder's only driver.

Parameters:
- CNT_W, 16: width of the completed-transaction counter op_count. Wraps modulo 2^CNT_W.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request, level; held until done0 seen.
- a0  input  8  requester 0 operand A.
- b0  input  8  requester 0 operand B.
- cin0  input  1  requester 0 carry-in.
- req1, a1, b1, cin1  input  1/8/8/1  requester 1, same meaning.
- gnt0, gnt1  output  1  requester currently owns the adder (one-hot or zero).
- done0, done1  output  1  result valid for that requester; held until its req falls.
- sum  output  8  registered result.
- cout  output  1  registered carry-out.
- ovf  output  1  registered signed overflow.
- busy  output  1  high whenever state is not IDLE.
- op_count  output  CNT_W  completed transactions.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high on rst. While rst=1, all of the following are 0: outputs, state (IDLE), operand registers and op_count. The round-robin pointer last resets to 1, so requester 0 wins first.
- FSM states: IDLE, CALC, ACK.
- IDLE:
  - At a clock edge with any req high, select the winner, latch its a/b/cin into internal operand registers, and set its gnt. Go to CALC.
  - Winner rules: only one req high wins. Both high, the requester != last wins.
- CALC:
  - The adder sees the latched operands only.
  - At the next edge, register sum<=S and cout<=Cout, and set the winner's done.
  - Compute ovf<=(A[7]==B[7])&&(S[7]!=A[7]).
  - Go to ACK.
- ACK:
  - done, gnt, sum, cout and ovf are held stable.
  - At the first edge where the winner's req is 0: clear done and gnt, set last<=winner, increment op_count, go to IDLE.
  - sum, cout and ovf keep their last value after release until the next CALC.
- Latency:
  - req sampled at edge k, gnt visible after edge k, done visible after edge k+1.
  - The minimum transaction is 3 cycles per requester, including the release cycle.
- Operand stability: a/b/cin changes after the IDLE sampling edge are ignored for that transaction.
- Loser handling: the losing req is not dropped. It is served in the IDLE cycle after release if still high. No back-to-back grant without an intervening IDLE cycle.
- Starvation: none, because requests alternate when both are persistently high.
- The non-granted requester's req toggling during CALC/ACK has no effect.
- Reset mid-operation: asynchronous clear to IDLE. The transaction is discarded, done/gnt drop immediately and op_count becomes 0.
- Arithmetic: {cout,sum} = a + b + cin, 9-bit unsigned. ovf uses the two's-complement interpretation.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset: assert rst mid-simulation asynchronously -> gnt0/1, done0/1, sum, cout, ovf, busy, op_count all 0 before the next clk edge.
- Single requester: req0=1, a0=10, b0=5, cin0=0 -> gnt0=1 after 1 edge, done0=1 after 2 edges, sum=15, cout=0, ovf=0. Drop req0 -> done0=0 next edge, op_count=1.
- Signed overflow: req1=1, a1=127, b1=1, cin1=0 -> done1, sum=128, cout=0, ovf=1. Change a1 to 0 during CALC -> result unchanged.
- Contention from reset: req0 (a0=200, b0=100, cin0=1) and req1 (a1=8'hFF, b1=8'h01, cin1=0) both high.
  - Requester 0 is served first: sum=45, cout=1, ovf=0.
  - After req0 drops and is re-raised, requester 1 is served next: sum=0, cout=1, ovf=0.
  - Requester 0 is served third -> alternation confirmed.
- Reset during ACK: rst pulse while done0=1 -> done0, gnt0 and op_count cleared immediately. After release, req1 alone is served normally with last=1 behaviour.
- Counter wrap with CNT_W=2: 4 completed transactions -> op_count sequence 1,2,3,0.
